// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between the execute stage and a single-beat data bus.
//
// One access is in flight at a time. The unit accepts a naturally aligned
// load or store in IDLE, moves to BUSY and holds a request on the data bus
// until the bus acknowledges it or a wait budget runs out. Load data is
// lane-shifted and sign/zero-extended before it is returned upstream.
//
// Handshake: an access is offered when ex_valid_i & ex_mtype_i are high with
// a non-zero width. It is taken in the same cycle lsu_stall_o rises, and the
// upstream stage must keep its inputs stable while lsu_stall_o is high. On
// the bus side mem_req_o stays high, with address/we/be/wdata stable, until
// a mem_ack_i pulse; mem_rdata_i is sampled only in that ack cycle.
//
// Parameters
//   TIMEOUT            BUSY cycles without ack before the access is dropped
//                      (legal range 2..255)
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ex_valid_i         execute stage presents an instruction
//   ex_mtype_i         instruction is a load/store
//   ex_mem_rw_i        1 = load, 0 = store
//   ex_mem_width_i     1 = byte, 2 = half, 3 = word, 0 = invalid
//   ex_mem_rdtype_i    0 = sign-extend load, 1 = zero-extend load
//   ex_addr_i          effective byte address
//   ex_wdata_i         right-aligned store data
//   mem_req_o          bus request (high for the whole BUSY state)
//   mem_we_o           bus write enable
//   mem_addr_o         word-aligned bus address
//   mem_be_o           bus byte enables
//   mem_wdata_o        lane-replicated store data
//   mem_ack_i          one-cycle bus completion pulse
//   mem_rdata_i        bus read data, valid with mem_ack_i
//   lsu_stall_o        freeze upstream (combinational)
//   lsu_rdata_valid_o  one-cycle pulse, load result on lsu_rdata_o
//   lsu_rdata_o        extended load result (held between loads)
//   lsu_misalign_o     one-cycle pulse, access rejected as misaligned
//   lsu_timeout_o      one-cycle pulse, access abandoned without ack
//   dbg_state          current FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid_i,
    input  logic        ex_mtype_i,
    input  logic        ex_mem_rw_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic        ex_mem_rdtype_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,

    output logic        lsu_stall_o,
    output logic        lsu_rdata_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misalign_o,
    output logic        lsu_timeout_o,

    output logic        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Last counter value allowed in BUSY; reaching it without ack ends the access.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic [7:0]  wait_cnt;

    // Attributes of the access in flight, captured on acceptance.
    logic [1:0]  req_addr_lo;
    logic        req_load;
    logic [1:0]  req_width;
    logic        req_zext;

    logic        mem_op;
    logic        aligned;
    logic        accept;
    logic        misalign_req;
    logic        ack_busy;
    logic        timeout_hit;

    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] rdata_shifted;
    logic [31:0] rdata_ext;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign mem_op = ex_valid_i & ex_mtype_i & (ex_mem_width_i != 2'd0);

    always_comb begin
        aligned = 1'b0;
        case (ex_mem_width_i)
            2'd1:    aligned = 1'b1;
            2'd2:    aligned = ~ex_addr_i[0];
            2'd3:    aligned = (ex_addr_i[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign accept       = (state == IDLE) & mem_op &  aligned;
    assign misalign_req = (state == IDLE) & mem_op & ~aligned;
    assign ack_busy     = (state == BUSY) & mem_ack_i;
    // Ack has priority: a timeout is only declared when no ack arrives.
    assign timeout_hit  = (state == BUSY) & ~mem_ack_i & (wait_cnt == WAIT_LAST);

    // Byte enables and store-lane replication for the offered access.
    always_comb begin
        be_next    = 4'b0000;
        wdata_next = ex_wdata_i;
        case (ex_mem_width_i)
            2'd1: begin
                be_next    = 4'b0001 << ex_addr_i[1:0];
                wdata_next = {4{ex_wdata_i[7:0]}};
            end
            2'd2: begin
                be_next    = 4'b0011 << ex_addr_i[1:0];
                wdata_next = {2{ex_wdata_i[15:0]}};
            end
            2'd3: begin
                be_next    = 4'b1111;
                wdata_next = ex_wdata_i;
            end
            default: begin
                be_next    = 4'b0000;
                wdata_next = ex_wdata_i;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load data alignment and extension
    // -------------------------------------------------------------------------
    // Word loads are aligned, so the shift is zero and data passes unchanged.
    assign rdata_shifted = mem_rdata_i >> {req_addr_lo, 3'b000};

    always_comb begin
        rdata_ext = rdata_shifted;
        case (req_width)
            2'd1:    rdata_ext = {{24{~req_zext & rdata_shifted[7]}},  rdata_shifted[7:0]};
            2'd2:    rdata_ext = {{16{~req_zext & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: rdata_ext = rdata_shifted;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack_busy || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // The stall is forced low while reset is asserted so upstream is never
    // frozen by a state that is about to be cleared.
    always_comb begin
        mem_req_o   = (state == BUSY);
        lsu_stall_o = ~rst & (accept | ((state == BUSY) & ~mem_ack_i));
        dbg_state   = (state == BUSY);
    end

    // -------------------------------------------------------------------------
    // Wait counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (accept) begin
            wait_cnt <= 8'd0;
        end else if ((state == BUSY) && !mem_ack_i && !timeout_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Captured request and bus-side registers
    // -------------------------------------------------------------------------
    // Bus fields are written only on acceptance, so they stay stable for the
    // whole BUSY period and simply hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_lo <= 2'b00;
            req_load    <= 1'b0;
            req_width   <= 2'd0;
            req_zext    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= 32'd0;
        end else if (accept) begin
            req_addr_lo <= ex_addr_i[1:0];
            req_load    <= ex_mem_rw_i;
            req_width   <= ex_mem_width_i;
            req_zext    <= ex_mem_rdtype_i;
            mem_we_o    <= ~ex_mem_rw_i;
            mem_addr_o  <= {ex_addr_i[31:2], 2'b00};
            mem_be_o    <= be_next;
            mem_wdata_o <= wdata_next;
        end
    end

    // -------------------------------------------------------------------------
    // Upstream result and event pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_rdata_valid_o <= 1'b0;
            lsu_rdata_o       <= 32'd0;
            lsu_misalign_o    <= 1'b0;
            lsu_timeout_o     <= 1'b0;
        end else begin
            lsu_rdata_valid_o <= ack_busy & req_load;
            lsu_misalign_o    <= misalign_req;
            lsu_timeout_o     <= timeout_hit;
            // Store acks leave the previous load result in place.
            if (ack_busy && req_load) begin
                lsu_rdata_o <= rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- directed self-checking bench for lsu (TIMEOUT = 16).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge. A scoreboard queue holds the expected load results and is
// drained on every lsu_rdata_valid_o pulse.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_mtype_i;
    logic        ex_mem_rw_i;
    logic [1:0]  ex_mem_width_i;
    logic        ex_mem_rdtype_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        lsu_stall_o;
    logic        lsu_rdata_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misalign_o;
    logic        lsu_timeout_o;
    logic        dbg_state;

    int total;
    int bad;
    logic [31:0] exp_q[$];
    logic [31:0] exp_d;

    lsu #(.TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid_i        (ex_valid_i),
        .ex_mtype_i        (ex_mtype_i),
        .ex_mem_rw_i       (ex_mem_rw_i),
        .ex_mem_width_i    (ex_mem_width_i),
        .ex_mem_rdtype_i   (ex_mem_rdtype_i),
        .ex_addr_i         (ex_addr_i),
        .ex_wdata_i        (ex_wdata_i),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_be_o          (mem_be_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_ack_i         (mem_ack_i),
        .mem_rdata_i       (mem_rdata_i),
        .lsu_stall_o       (lsu_stall_o),
        .lsu_rdata_valid_o (lsu_rdata_valid_o),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_misalign_o    (lsu_misalign_o),
        .lsu_timeout_o     (lsu_timeout_o),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (lsu_rdata_valid_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_valid: got rdata=%h want no pulse", lsu_rdata_o);
            end else begin
                exp_d = exp_q.pop_front();
                if (lsu_rdata_o !== exp_d) begin
                    bad++;
                    $display("FAIL sb_rdata: got %h want %h", lsu_rdata_o, exp_d);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic rw, input logic [1:0] width, input logic zext,
                            input logic [31:0] addr, input logic [31:0] wdata);
        ex_valid_i      = 1'b1;
        ex_mtype_i      = 1'b1;
        ex_mem_rw_i     = rw;
        ex_mem_width_i  = width;
        ex_mem_rdtype_i = zext;
        ex_addr_i       = addr;
        ex_wdata_i      = wdata;
    endtask

    task automatic clear_ex();
        ex_valid_i      = 1'b0;
        ex_mtype_i      = 1'b0;
        ex_mem_rw_i     = 1'b0;
        ex_mem_width_i  = 2'd0;
        ex_mem_rdtype_i = 1'b0;
        ex_addr_i       = 32'd0;
        ex_wdata_i      = 32'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst         = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        // A valid aligned load during reset must not raise the stall.
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'd0);
        tick();
        tick();
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", lsu_stall_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        total++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 69'd0) begin bad++; $display("FAIL rst_bus: got we=%b be=%b addr=%h wdata=%h want all 0", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
        total++; if (lsu_rdata_o !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", lsu_rdata_o); end
        total++; if ({lsu_rdata_valid_o, lsu_misalign_o, lsu_timeout_o, dbg_state} !== 4'b0000) begin bad++; $display("FAIL rst_pulses: got %b want 0000", {lsu_rdata_valid_o, lsu_misalign_o, lsu_timeout_o, dbg_state}); end
        tick();
        rst = 1'b0;
        clear_ex();
    endtask

    // Single-beat load acked in the first BUSY cycle.
    task automatic run_load(input string tag, input logic [1:0] width, input logic zext,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_rdata);
        tick();
        drive_ex(1'b1, width, zext, addr, 32'd0);
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b1) begin bad++; $display("FAIL %s_accept_stall: got %b want 1", tag, lsu_stall_o); end
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        exp_q.push_back(exp_rdata);
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin bad++; $display("FAIL %s_req: got req=%b we=%b want req=1 we=0", tag, mem_req_o, mem_we_o); end
        total++; if (mem_addr_o !== exp_addr) begin bad++; $display("FAIL %s_addr: got %h want %h", tag, mem_addr_o, exp_addr); end
        total++; if (mem_be_o !== exp_be) begin bad++; $display("FAIL %s_be: got %b want %b", tag, mem_be_o, exp_be); end
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL %s_ack_stall: got %b want 0", tag, lsu_stall_o); end
        tick();
        mem_ack_i = 1'b0;
        clear_ex();
        @(negedge clk);
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL %s_req_drop: got %b want 0", tag, mem_req_o); end
        total++; if (lsu_rdata_valid_o !== 1'b1 || lsu_rdata_o !== exp_rdata) begin bad++; $display("FAIL %s_rdata: got v=%b d=%h want v=1 d=%h", tag, lsu_rdata_valid_o, lsu_rdata_o, exp_rdata); end
        tick();
        @(negedge clk);
        total++; if (lsu_rdata_valid_o !== 1'b0) begin bad++; $display("FAIL %s_valid_once: got %b want 0", tag, lsu_rdata_valid_o); end
    endtask

    task automatic test_load_byte();
        run_load("lb",  2'd1, 1'b0, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
        run_load("lbu", 2'd1, 1'b1, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_1000, 4'b1000, 32'h0000_0080);
    endtask

    task automatic test_store_half();
        tick();
        drive_ex(1'b0, 2'd2, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b1) begin bad++; $display("FAIL sh_accept_stall: got %b want 1", lsu_stall_o); end
        tick();
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || lsu_stall_o !== 1'b1) begin bad++; $display("FAIL sh_busy: got req=%b we=%b stall=%b want 1 1 1", mem_req_o, mem_we_o, lsu_stall_o); end
        total++; if (mem_addr_o !== 32'h0000_2000 || mem_be_o !== 4'b1100) begin bad++; $display("FAIL sh_addr_be: got %h %b want 00002000 1100", mem_addr_o, mem_be_o); end
        total++; if (mem_wdata_o !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %h want abcdabcd", mem_wdata_o); end
        tick();
        mem_ack_i = 1'b1;
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL sh_ack_stall: got %b want 0", lsu_stall_o); end
        total++; if (mem_wdata_o !== 32'hABCD_ABCD || mem_be_o !== 4'b1100) begin bad++; $display("FAIL sh_hold: got %h %b want abcdabcd 1100", mem_wdata_o, mem_be_o); end
        tick();
        mem_ack_i = 1'b0;
        clear_ex();
        @(negedge clk);
        total++; if (mem_req_o !== 1'b0 || lsu_rdata_valid_o !== 1'b0) begin bad++; $display("FAIL sh_done: got req=%b valid=%b want 0 0", mem_req_o, lsu_rdata_valid_o); end
        total++; if (lsu_rdata_o !== 32'h0000_0080) begin bad++; $display("FAIL sh_rdata_hold: got %h want 00000080", lsu_rdata_o); end
    endtask

    task automatic test_misalign();
        tick();
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0000_3001, 32'd0);
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", lsu_stall_o); end
        tick();
        clear_ex();
        @(negedge clk);
        total++; if (lsu_misalign_o !== 1'b1 || mem_req_o !== 1'b0) begin bad++; $display("FAIL mis_pulse: got mis=%b req=%b want 1 0", lsu_misalign_o, mem_req_o); end
        tick();
        @(negedge clk);
        total++; if (lsu_misalign_o !== 1'b0 || mem_req_o !== 1'b0 || dbg_state !== 1'b0) begin bad++; $display("FAIL mis_once: got mis=%b req=%b st=%b want 0 0 0", lsu_misalign_o, mem_req_o, dbg_state); end
    endtask

    task automatic test_no_action();
        // Width 0 at an odd address: neither accepted nor flagged.
        tick();
        drive_ex(1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'd0);
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL w0_stall: got %b want 0", lsu_stall_o); end
        // Non-memory instruction.
        tick();
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0000_3001, 32'd0);
        ex_mtype_i = 1'b0;
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0 || lsu_misalign_o !== 1'b0) begin bad++; $display("FAIL nomem: got stall=%b mis=%b want 0 0", lsu_stall_o, lsu_misalign_o); end
        // Stray ack in IDLE.
        tick();
        clear_ex();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        total++; if (lsu_misalign_o !== 1'b0) begin bad++; $display("FAIL nomem_mis: got %b want 0", lsu_misalign_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        total++; if ({mem_req_o, lsu_rdata_valid_o, lsu_timeout_o, dbg_state} !== 4'b0000) begin bad++; $display("FAIL idle_ack: got %b want 0000", {mem_req_o, lsu_rdata_valid_o, lsu_timeout_o, dbg_state}); end
        total++; if (lsu_rdata_o !== 32'h0000_0080) begin bad++; $display("FAIL idle_ack_rdata: got %h want 00000080", lsu_rdata_o); end
    endtask

    task automatic test_timeout();
        int req_cnt;
        int to_cnt;
        int to_idx;
        req_cnt = 0;
        to_cnt  = 0;
        to_idx  = -1;
        tick();
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0000_4000, 32'd0);
        tick();
        clear_ex();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1) req_cnt++;
            if (lsu_timeout_o === 1'b1) begin
                to_cnt++;
                to_idx = i;
            end
        end
        total++; if (req_cnt != 16) begin bad++; $display("FAIL to_req_cycles: got %0d want 16", req_cnt); end
        total++; if (to_cnt != 1 || to_idx != 16) begin bad++; $display("FAIL to_pulse: got count=%0d at=%0d want count=1 at=16", to_cnt, to_idx); end
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", dbg_state); end
    endtask

    task automatic test_ack_at_limit();
        int to_cnt;
        to_cnt = 0;
        tick();
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0000_5000, 32'd0);
        tick();
        clear_ex();
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (lsu_timeout_o === 1'b1 || mem_req_o !== 1'b1) to_cnt++;
            tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        total++; if (to_cnt != 0 || mem_req_o !== 1'b1) begin bad++; $display("FAIL lim_wait: got early=%0d req=%b want 0 1", to_cnt, mem_req_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        total++; if (lsu_timeout_o !== 1'b0) begin bad++; $display("FAIL lim_timeout: got %b want 0", lsu_timeout_o); end
        total++; if (lsu_rdata_valid_o !== 1'b1 || lsu_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lim_rdata: got v=%b d=%h want 1 deadbeef", lsu_rdata_valid_o, lsu_rdata_o); end
        tick();
        @(negedge clk);
        total++; if (lsu_timeout_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL lim_after: got to=%b req=%b want 0 0", lsu_timeout_o, mem_req_o); end
    endtask

    task automatic test_reset_busy();
        tick();
        drive_ex(1'b1, 2'd3, 1'b0, 32'h0000_6000, 32'd0);
        tick();
        clear_ex();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL rb_stall: got %b want 0", lsu_stall_o); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b0 || dbg_state !== 1'b0) begin bad++; $display("FAIL rb_req: got req=%b st=%b want 0 0", mem_req_o, dbg_state); end
        total++; if ({lsu_rdata_valid_o, lsu_misalign_o, lsu_timeout_o} !== 3'b000 || lsu_rdata_o !== 32'd0) begin bad++; $display("FAIL rb_pulses: got %b rdata=%h want 000 0", {lsu_rdata_valid_o, lsu_misalign_o, lsu_timeout_o}, lsu_rdata_o); end
        tick();
        @(negedge clk);
        total++; if ({lsu_rdata_valid_o, lsu_misalign_o, lsu_timeout_o} !== 3'b000) begin bad++; $display("FAIL rb_quiet: got %b want 000", {lsu_rdata_valid_o, lsu_misalign_o, lsu_timeout_o}); end
        run_load("lhu", 2'd2, 1'b1, 32'h0000_0002, 32'h8001_0000, 32'h0000_0000, 4'b1100, 32'h0000_8001);
    endtask

    task automatic test_back_to_back();
        tick();
        drive_ex(1'b1, 2'd2, 1'b0, 32'h0000_7002, 32'd0);
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hF00F_1234;
        exp_q.push_back(32'hFFFF_F00F);
        @(negedge clk);
        total++; if (mem_be_o !== 4'b1100 || mem_addr_o !== 32'h0000_7000) begin bad++; $display("FAIL b2b_lh_bus: got be=%b addr=%h want 1100 00007000", mem_be_o, mem_addr_o); end
        tick();
        mem_ack_i = 1'b0;
        drive_ex(1'b0, 2'd1, 1'b0, 32'h0000_7001, 32'h0000_00A5);
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin bad++; $display("FAIL b2b_bubble: got stall=%b req=%b want 1 0", lsu_stall_o, mem_req_o); end
        total++; if (lsu_rdata_valid_o !== 1'b1 || lsu_rdata_o !== 32'hFFFF_F00F) begin bad++; $display("FAIL b2b_lh_rdata: got v=%b d=%h want 1 fffff00f", lsu_rdata_valid_o, lsu_rdata_o); end
        tick();
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_7000) begin bad++; $display("FAIL b2b_sb_req: got req=%b we=%b addr=%h want 1 1 00007000", mem_req_o, mem_we_o, mem_addr_o); end
        total++; if (mem_be_o !== 4'b0010 || mem_wdata_o !== 32'hA5A5_A5A5) begin bad++; $display("FAIL b2b_sb_data: got be=%b wdata=%h want 0010 a5a5a5a5", mem_be_o, mem_wdata_o); end
        tick();
        clear_ex();
        mem_ack_i = 1'b1;
        @(negedge clk);
        total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL b2b_sb_ack_stall: got %b want 0", lsu_stall_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b0 || lsu_rdata_valid_o !== 1'b0 || lsu_rdata_o !== 32'hFFFF_F00F) begin bad++; $display("FAIL b2b_sb_done: got req=%b v=%b d=%h want 0 0 fffff00f", mem_req_o, lsu_rdata_valid_o, lsu_rdata_o); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        clear_ex();
        test_reset();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_no_action();
        test_timeout();
        test_ack_at_limit();
        test_reset_busy();
        test_back_to_back();
        tick();
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of cycles without mem_ack_i in BUSY before the access is abandoned; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 ex_valid_i  input  1  execute stage presents an instruction this cycle.
REQ-005 ex_mtype_i  input  1  1 = load/store instruction.
REQ-006 ex_mem_rw_i  input  1  1 = load, 0 = store.
REQ-007 ex_mem_width_i  input  2  1 = byte, 2 = half, 3 = word, 0 = invalid.
REQ-008 ex_mem_rdtype_i  input  1  0 = sign-extend load, 1 = zero-extend load.
REQ-009 ex_addr_i  input  32  effective address (ALU ADD result).
REQ-010 ex_wdata_i  input  32  store data (rs2), right-aligned.
REQ-011 mem_req_o  output  1  data-bus request.
REQ-012 mem_we_o  output  1  1 = write.
REQ-013 mem_addr_o  output  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-014 mem_be_o  output  4  byte enables.
REQ-015 mem_wdata_o  output  32  lane-replicated store data.
REQ-016 mem_ack_i  input  1  bus completion, one-cycle pulse.
REQ-017 mem_rdata_i  input  32  read data, valid when mem_ack_i = 1.
REQ-018 lsu_stall_o  output  1  freeze the upstream pipeline.
REQ-019 lsu_rdata_valid_o  output  1  one-cycle pulse: load result is ready.
REQ-020 lsu_rdata_o  output  32  extended load result.
REQ-021 lsu_misalign_o  output  1  one-cycle pulse: access rejected as misaligned.
REQ-022 lsu_timeout_o  output  1  one-cycle pulse: access abandoned.

Function
REQ-023 FSM: IDLE, BUSY. An access is accepted in IDLE when ex_valid_i & ex_mtype_i & (ex_mem_width_i != 0) & aligned.
- Aligned means: byte, any address; half, addr[0] = 0; word, addr[1:0] = 0.
- On acceptance the block registers addr, rw, width, rdtype and wdata, and enters BUSY at the next edge.
REQ-024 Width 0 or ex_mtype_i = 0: no action, no stall, no pulse.
REQ-025 Misaligned request in IDLE:
- lsu_misalign_o pulses in the following cycle.
- No bus request is issued, no stall, FSM stays IDLE.
REQ-026 In BUSY, mem_req_o = 1, and mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are held stable until ack or timeout.
REQ-027 Byte enables:
- byte: 4'b0001 << addr[1:0]
- half: 4'b0011 << addr[1:0]
- word: 4'b1111
REQ-028 Store data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
REQ-029 lsu_stall_o = (IDLE & accept) | (BUSY & ~mem_ack_i); the stall is combinational.
REQ-030 mem_ack_i in BUSY returns the FSM to IDLE at the next edge, and mem_req_o is low in the following cycle.
- For a load, lsu_rdata_valid_o pulses in the cycle after ack, with lsu_rdata_o registered.
REQ-031 Load data is mem_rdata_i >> (8*addr[1:0]), then sign- or zero-extended from bit 7 (byte) or bit 15 (half) per rdtype; word loads are passed through unchanged.
REQ-032 A store ack produces no rdata_valid pulse; lsu_rdata_o holds its previous value.
REQ-033 A wait counter clears on entering BUSY and increments each BUSY cycle without ack.
- When the counter reaches TIMEOUT-1 without ack, the FSM returns to IDLE at the next edge and lsu_timeout_o pulses in the next cycle.
REQ-034 Ack and timeout in the same cycle: ack wins, and no timeout pulse is raised.
REQ-035 mem_ack_i while in IDLE is ignored.
REQ-036 ex_valid_i while in BUSY is ignored; upstream holds its request because it is stalled.
REQ-037 Back-to-back accesses: a new access can be accepted in the first IDLE cycle after completion, which is one bubble minimum.

Reset
REQ-038 When rst = 1 at a rising edge, the FSM goes to IDLE and the counter is cleared.
- Outputs go to: mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_be_o = 0, mem_wdata_o = 0, lsu_rdata_o = 0, all pulses = 0.
- lsu_stall_o = 0 during reset.
REQ-039 Reset mid-BUSY abandons the access with no pulse, and mem_req_o is low in the cycle after the reset edge.

Verification
REQ-040 LB at 0x1003, rdata 0x80FF_FF00, sign:
- Expected: be 4'b1000, addr 0x1000, rdata_o 0xFFFF_FF80.
- Repeat as LBU: expected rdata_o 0x0000_0080.
REQ-041 SH at 0x2002, wdata 0x1234_ABCD:
- Expected: we = 1, be 4'b1100, wdata_o 0xABCD_ABCD.
- Expected: no rdata_valid pulse, stall drops in the ack cycle.
REQ-042 LW at 0x3001:
- Expected: lsu_misalign_o pulses once, mem_req_o stays 0, no stall.
REQ-043 LW with no ack, TIMEOUT = 16:
- Expected: req high for exactly 16 cycles, then timeout pulses once and the FSM is in IDLE.
- Repeat with ack in cycle 16: expected no timeout and rdata_valid pulses.
REQ-044 rst asserted in the 3rd BUSY cycle:
- Expected: req low the next cycle, no pulses.
- Then a LHU at 0x0002 with rdata 0x8001_0000: expected rdata_o 0x0000_8001.
